muldiv_unit: RTL and testbench

Iterative 8-bit multiply/divide execution unit for the MUL REG,REG and DIV REG,REG (and signed IMUL/IDIV) instructions. It sits directly downstream of the instruction decoder. The decoder issues operands read from the register file plus an op code. It holds the instruction open while busy, then writes res_hi/res_lo back and updates flags when done pulses. The unit has a one-bit-per-cycle datapath: a shift-add multiplier and a restoring divider that share one accumulator.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the instruction decoder and the
// multiply/divide unit: operands and op code in, results and flags out.
interface muldiv_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [7:0]       flags;

    modport master (
        output start, op, a, b,
        input  busy, done, res_hi, res_lo, flags
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, res_hi, res_lo, flags
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit (MUL, IMUL, DIV, IDIV). One bit per clock:
// a shift-add multiplier and a restoring divider share one double-width
// accumulator and work on operand magnitudes; signs are re-applied on the
// final iteration together with the flag byte.
module muldiv_unit #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q;
    logic [1:0]           op_q;
    logic [2*WIDTH-1:0]   acc_q;      // MUL: {partial high, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]     opd_q;      // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic                 neg_res_q;  // product / quotient must be negated
    logic                 neg_rem_q;  // remainder must be negated (dividend sign)
    logic [CNT_W-1:0]     count_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     res_hi_q;
    logic [WIDTH-1:0]     res_lo_q;
    logic [7:0]           flags_q;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum_w, rs_w, diff_w;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix, ext;
    logic [WIDTH-1:0]     res_hi_d, res_lo_d;
    logic [7:0]           flags_d;
    logic                 ovf;

    function automatic logic parity_even(input logic [WIDTH-1:0] v);
        return ~^v;
    endfunction

    function automatic logic [7:0] pack_flags(input logic vf, input logic pf, input logic sf,
                                              input logic zf, input logic af, input logic cf);
        return {2'b00, vf, pf, sf, zf, af, cf};
    endfunction

    // Operand magnitudes and signs for the incoming request (signed ops only)
    always_comb begin
        a_neg = bus.op[0] & bus.a[WIDTH-1];
        b_neg = bus.op[0] & bus.b[WIDTH-1];
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;
    end

    // One iteration of shift-add multiply or restoring divide, then sign fix-up and flags
    always_comb begin
        sum_w  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        rs_w   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff_w = rs_w - {1'b0, opd_q};
        if (!op_q[1]) begin
            acc_step = {sum_w, acc_q[WIDTH-1:1]};
        end else if (!diff_w[WIDTH]) begin
            acc_step = {diff_w[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {rs_w[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        prod_fix = neg_res_q ? -acc_step : acc_step;
        quo_fix  = neg_res_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

        if (!op_q[1]) begin
            res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
            res_lo_d = prod_fix[WIDTH-1:0];
            ext      = op_q[0] ? {WIDTH{res_lo_d[WIDTH-1]}} : '0;
            ovf      = (res_hi_d != ext);
            flags_d  = pack_flags(ovf, parity_even(res_lo_d), res_hi_d[WIDTH-1],
                                  (prod_fix == '0), 1'b0, ovf);
        end else begin
            res_hi_d = rem_fix;
            res_lo_d = quo_fix;
            ext      = '0;
            // Only -2^(W-1) / -1 yields a positive quotient magnitude of 2^(W-1)
            ovf      = op_q[0] & ~neg_res_q & acc_step[WIDTH-1];
            flags_d  = pack_flags(ovf, parity_even(res_lo_d), res_lo_d[WIDTH-1],
                                  (res_lo_d == '0), 1'b0, 1'b0);
        end
    end

    // Control FSM: accept, iterate WIDTH times, publish results with a one-cycle done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            flags_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    acc_q   <= acc_step;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == LAST) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        res_hi_q <= res_hi_d;
                        res_lo_q <= res_lo_d;
                        flags_q  <= flags_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    if (bus.start) begin
                        op_q      <= bus.op;
                        count_q   <= '0;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (bus.op[1] && (bus.b == '0)) begin
                            // Divide by zero completes immediately with fixed results
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            res_hi_q <= bus.a;
                            res_lo_q <= '1;
                            flags_q  <= pack_flags(1'b1, parity_even({WIDTH{1'b1}}), 1'b1,
                                                   1'b0, 1'b0, 1'b0);
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            if (bus.op[1]) begin
                                acc_q <= {{WIDTH{1'b0}}, a_mag};
                                opd_q <= b_mag;
                            end else begin
                                acc_q <= {{WIDTH{1'b0}}, b_mag};
                                opd_q <= a_mag;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.res_hi = res_hi_q;
    assign bus.res_lo = res_lo_q;
    assign bus.flags  = flags_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level reference model from integer arithmetic,
// per-cycle output comparison, directed literal cases and randomized traffic.
module tb_muldiv_unit;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] fl;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural result of one instruction, from plain integer arithmetic
    function automatic res_t ref_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int   sa, sb, p, q, r;
        logic cf, vf;
        res_t o;
        sa = op[0] ? int'($signed(a)) : int'(a);
        sb = op[0] ? int'($signed(b)) : int'(b);
        if (!op[1]) begin
            p    = sa * sb;
            o.hi = 8'(p >>> 8);
            o.lo = 8'(p);
            cf   = op[0] ? (p < -128 || p > 127) : (p > 255);
            o.fl = {2'b00, cf, ~^o.lo, o.hi[7], (p == 0), 1'b0, cf};
        end else if (b == 8'h00) begin
            o.lo = 8'hFF;
            o.hi = a;
            o.fl = {2'b00, 1'b1, ~^o.lo, o.lo[7], 1'b0, 1'b0, 1'b0};
        end else begin
            if (op[0] && sa == -128 && sb == -1) begin
                q  = 128;
                r  = 0;
                vf = 1'b1;
            end else begin
                q  = sa / sb;
                r  = sa % sb;
                vf = 1'b0;
            end
            o.lo = 8'(q);
            o.hi = 8'(r);
            o.fl = {2'b00, vf, ~^o.lo, o.lo[7], (o.lo == 8'h00), 1'b0, 1'b0};
        end
        return o;
    endfunction

    // Timing model: a request outside a run starts a W-cycle countdown
    logic m_busy, m_done;
    logic [7:0] m_hi, m_lo, m_fl;
    int   m_rem;
    res_t m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= 8'h00;
            m_lo   <= 8'h00;
            m_fl   <= 8'h00;
            m_rem  <= 0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_pend.hi;
                    m_lo   <= m_pend.lo;
                    m_fl   <= m_pend.fl;
                end
            end else if (bus.start) begin
                if (bus.op[1] && bus.b == 8'h00) begin
                    m_done <= 1'b1;
                    {m_hi, m_lo, m_fl} <= ref_model(bus.op, bus.a, bus.b);
                end else begin
                    m_pend <= ref_model(bus.op, bus.a, bus.b);
                    m_busy <= 1'b1;
                    m_rem  <= W;
                end
            end
        end
    end

    // Every cycle, away from the active edge, the DUT must match the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   bus.busy,   m_busy);
            chk("done",   bus.done,   m_done);
            chk("res_hi", bus.res_hi, m_hi);
            chk("res_lo", bus.res_lo, m_lo);
            chk("flags",  bus.flags,  m_fl);
        end
    end

    // Called at a negedge: present a request for one cycle
    task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts cycles from the start cycle until done is seen (bounded)
    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (bus.done !== 1'b1) chk("done_timeout", bus.done, 1);
    endtask

    task automatic dir(input string nm, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ehi, input logic [7:0] elo, input logic [7:0] efl, input int elat);
        int lat;
        drive(op, a, b);
        wait_done(lat);
        chk({nm, "_lat"}, lat, elat);
        chk({nm, "_hi"}, bus.res_hi, ehi);
        chk({nm, "_lo"}, bus.res_lo, elo);
        chk({nm, "_fl"}, bus.flags, efl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [1:0] rop;
        logic [7:0] ra, rb;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_hi",   bus.res_hi, 0);
        chk("rst_lo",   bus.res_lo, 0);
        chk("rst_fl",   bus.flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-computed results
        dir("mul",    2'b00, 8'd200, 8'd3,  8'h02, 8'h58, 8'h21, 9);
        @(negedge clk);
        dir("imul1",  2'b01, 8'hFD,  8'h05, 8'hFF, 8'hF1, 8'h08, 9);
        dir("imul2",  2'b01, 8'h80,  8'h80, 8'h40, 8'h00, 8'h31, 9);
        @(negedge clk);
        dir("div1",   2'b10, 8'd200, 8'd7,  8'h04, 8'h1C, 8'h00, 9);
        dir("div2",   2'b10, 8'd5,   8'd9,  8'h05, 8'h00, 8'h14, 9);
        @(negedge clk);
        dir("idiv1",  2'b11, 8'hF9,  8'h02, 8'hFF, 8'hFD, 8'h08, 9);
        dir("idivov", 2'b11, 8'h80,  8'hFF, 8'h00, 8'h80, 8'h28, 9);
        dir("div0",   2'b10, 8'h33,  8'h00, 8'h33, 8'hFF, 8'h38, 1);
        @(negedge clk);

        // A start during a run is ignored; one in the done cycle is accepted
        drive(2'b00, 8'd200, 8'd3);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 8'd10;
        bus.b     = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        chk("ign_lat", lat + 2, 9);
        chk("ign_hi",  bus.res_hi, 8'h02);
        chk("ign_lo",  bus.res_lo, 8'h58);
        chk("ign_fl",  bus.flags,  8'h21);
        dir("b2b",    2'b01, 8'hFD,  8'h05, 8'hFF, 8'hF1, 8'h08, 9);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        drive(2'b10, 8'd200, 8'd7);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_hi",   bus.res_hi, 0);
        chk("arst_lo",   bus.res_lo, 0);
        chk("arst_fl",   bus.flags, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            chk("arst_nodone", bus.done, 0);
        end
        dir("post_rst", 2'b10, 8'd200, 8'd7, 8'h04, 8'h1C, 8'h00, 9);

        // Randomized traffic with spurious starts while busy
        repeat (150) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                ra = 8'h80;
                rb = 8'hFF;
            end
            drive(rop, ra, rb);
            lat = 1;
            while (bus.done !== 1'b1 && lat < 30) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.start = 1'b1;
                    bus.op    = 2'($urandom_range(0, 3));
                    bus.a     = 8'($urandom);
                    bus.b     = 8'($urandom);
                end else begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
            bus.start = 1'b0;
            chk("rnd_lat", lat, (rop[1] && rb == 8'h00) ? 1 : 9);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
